// File: rtl/issue_fifo_param_if.sv
// ---------------------------------------------------------------------------
// issue_fifo_param_if
//   Bundle between the scheduler/sequencer side and the parametrised issue
//   FIFO. The master modport drives the requests (write, pop, flush, error
//   clear). The slave modport is the FIFO, which returns the head entry, the
//   last popped entry, the occupancy/free-space levels, the threshold flags
//   and the sticky error flags.
//
//   Signals:
//     flush          master->slave  discard all entries this cycle
//     wen, data_in   master->slave  write request and data
//     ren            master->slave  pop request
//     err_clr        master->slave  clear the sticky error flags
//     data_out       slave->master  head entry, zero when empty
//     data_out_pre   slave->master  registered copy of the last popped entry
//     count          slave->master  occupancy, 0..DEPTH
//     free_space     slave->master  DEPTH - count
//     empty, virtual_full, full      level flags
//     overflow_err, underflow_err    sticky error flags
// ---------------------------------------------------------------------------
interface issue_fifo_param_if #(
    parameter int DATA_W = 21,
    parameter int DEPTH  = 32
);
    localparam int AW = $clog2(DEPTH);

    logic              flush;
    logic              wen;
    logic [DATA_W-1:0] data_in;
    logic              ren;
    logic              err_clr;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] data_out_pre;
    logic [AW:0]       count;
    logic [AW:0]       free_space;
    logic              empty;
    logic              virtual_full;
    logic              full;
    logic              overflow_err;
    logic              underflow_err;

    modport master (
        output flush, wen, data_in, ren, err_clr,
        input  data_out, data_out_pre, count, free_space, empty,
               virtual_full, full, overflow_err, underflow_err
    );

    modport slave (
        input  flush, wen, data_in, ren, err_clr,
        output data_out, data_out_pre, count, free_space, empty,
               virtual_full, full, overflow_err, underflow_err
    );
endinterface

// File: rtl/issue_fifo_param.sv
// ---------------------------------------------------------------------------
// issue_fifo_param
//   Parametrised issue FIFO holding {command, addr, bank} words between the
//   scheduler (writer) and the DRAM command sequencer (reader).
//
//   Ports:
//     clk    rising-edge clock for all logic
//     rst_n  synchronous active-low reset
//     bus    issue_fifo_param_if.slave (requests in, data/levels/flags out)
//
//   Parameters:
//     DATA_W       entry width
//     DEPTH        number of entries, power of two, >= 4
//     AFULL_SPACE  virtual_full when free space < AFULL_SPACE
//     FULL_SPACE   full when free space < FULL_SPACE
//                  (1 <= FULL_SPACE <= AFULL_SPACE <= DEPTH)
//
//   Pointers carry one extra wrap bit so count = wr_ptr - rd_ptr is exact
//   over 0..DEPTH. full/virtual_full are advisory reserves; only a hard
//   full (count == DEPTH) without a simultaneous pop drops a write.
// ---------------------------------------------------------------------------
module issue_fifo_param #(
    parameter int DATA_W      = 21,
    parameter int DEPTH       = 32,
    parameter int AFULL_SPACE = 8,
    parameter int FULL_SPACE  = 4
) (
    input logic               clk,
    input logic               rst_n,
    issue_fifo_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [AW:0] DEPTH_P   = PW'(DEPTH);
    localparam logic [AW:0] AFULL_P   = PW'(AFULL_SPACE);
    localparam logic [AW:0] FULL_P    = PW'(FULL_SPACE);
    localparam logic [AW:0] PTR_ONE   = PW'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] data_out_pre_q, data_out_pre_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic [AW:0]       count_w;
    logic [AW:0]       free_w;
    logic              empty_w;
    logic              hard_full_w;
    logic              wr_acc_w;
    logic              rd_acc_w;
    logic [DATA_W-1:0] head_w;

    // Levels and accept decisions, all from the registered pointers.
    always_comb begin
        count_w     = wr_ptr_q - rd_ptr_q;
        free_w      = DEPTH_P - count_w;
        empty_w     = (count_w == '0);
        hard_full_w = (count_w == DEPTH_P);
        // A pop in the same cycle frees the slot a hard-full write needs.
        wr_acc_w    = bus.wen && !bus.flush && (!hard_full_w || bus.ren);
        // No fall-through: a write into an empty FIFO cannot be popped yet.
        rd_acc_w    = bus.ren && !bus.flush && !empty_w;
        head_w      = empty_w ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        data_out_pre_d = data_out_pre_q;
        overflow_d     = overflow_q;
        underflow_d    = underflow_q;

        if (bus.flush) begin
            // Flush discards the contents but keeps the last popped word
            // and the error history.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc_w) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc_w) begin
                rd_ptr_d       = rd_ptr_q + PTR_ONE;
                data_out_pre_d = head_w;
            end
            // Set has priority over clear.
            if (bus.wen && hard_full_w && !bus.ren) begin
                overflow_d = 1'b1;
            end else if (bus.err_clr) begin
                overflow_d = 1'b0;
            end
            if (bus.ren && empty_w) begin
                underflow_d = 1'b1;
            end else if (bus.err_clr) begin
                underflow_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            data_out_pre_q <= '0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            data_out_pre_q <= data_out_pre_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    // Storage is not reset; it is only ever read through a valid pointer.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc_w) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.data_in;
        end
    end

    assign bus.data_out      = head_w;
    assign bus.data_out_pre  = data_out_pre_q;
    assign bus.count         = count_w;
    assign bus.free_space    = free_w;
    assign bus.empty         = empty_w;
    assign bus.virtual_full  = (free_w < AFULL_P);
    assign bus.full          = (free_w < FULL_P);
    assign bus.overflow_err  = overflow_q;
    assign bus.underflow_err = underflow_q;

endmodule

// File: tb/tb_issue_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_issue_fifo_param
//   Directed bench for issue_fifo_param (DATA_W=21, DEPTH=32, AFULL_SPACE=8,
//   FULL_SPACE=4). Inputs change 1 time unit after the rising edge, outputs
//   are checked at that same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_issue_fifo_param;
    localparam int DATA_W = 21;
    localparam int DEPTH  = 32;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    issue_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    issue_fifo_param #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .AFULL_SPACE(8),
        .FULL_SPACE (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic check_reset_state();
        check_val("rst_count",  32'(bus.count), 0);
        check_val("rst_free",   32'(bus.free_space), 32);
        check_val("rst_empty",  32'(bus.empty), 1);
        check_val("rst_full",   32'(bus.full), 0);
        check_val("rst_vfull",  32'(bus.virtual_full), 0);
        check_val("rst_pre",    32'(bus.data_out_pre), 0);
        check_val("rst_ovf",    32'(bus.overflow_err), 0);
        check_val("rst_udf",    32'(bus.underflow_err), 0);
        check_val("rst_dout",   32'(bus.data_out), 0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.flush    = 1'b0;
        bus.wen      = 1'b0;
        bus.ren      = 1'b0;
        bus.err_clr  = 1'b0;
        bus.data_in  = '0;
        tick();
        tick();
        rst_n = 1'b1;
        check_reset_state();

        // 32 writes of 0..31; thresholds crossed at free=7 and free=3.
        for (int i = 0; i < 32; i++) begin
            bus.wen     = 1'b1;
            bus.data_in = DATA_W'(i);
            tick();
            check_val($sformatf("fill_count_%0d", i), 32'(bus.count), 32'(i + 1));
            check_val($sformatf("fill_vfull_%0d", i), 32'(bus.virtual_full),
                      (i >= 24) ? 32'd1 : 32'd0);
            check_val($sformatf("fill_full_%0d", i), 32'(bus.full),
                      (i >= 28) ? 32'd1 : 32'd0);
        end
        bus.wen = 1'b0;
        check_val("fill_free",  32'(bus.free_space), 0);
        check_val("fill_empty", 32'(bus.empty), 0);
        check_val("fill_ovf",   32'(bus.overflow_err), 0);

        // Write into a hard-full FIFO is dropped.
        bus.wen     = 1'b1;
        bus.data_in = 21'h0ABCD;
        tick();
        bus.wen = 1'b0;
        check_val("ovf_flag",  32'(bus.overflow_err), 1);
        check_val("ovf_count", 32'(bus.count), 32);
        check_val("ovf_head",  32'(bus.data_out), 0);

        // Drain in order; data_out_pre follows one cycle later.
        for (int i = 0; i < 32; i++) begin
            bus.ren = 1'b1;
            check_val($sformatf("pop_dout_%0d", i), 32'(bus.data_out), 32'(i));
            tick();
            check_val($sformatf("pop_pre_%0d", i), 32'(bus.data_out_pre), 32'(i));
        end
        bus.ren = 1'b0;
        check_val("drain_empty", 32'(bus.empty), 1);
        check_val("drain_dout",  32'(bus.data_out), 0);
        check_val("drain_udf",   32'(bus.underflow_err), 0);

        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check_val("clr1_ovf", 32'(bus.overflow_err), 0);

        // Pre-fill 8, then 100 cycles of simultaneous write and pop.
        for (int k = 0; k < 8; k++) begin
            bus.wen     = 1'b1;
            bus.data_in = DATA_W'(32'h100 + k);
            tick();
        end
        for (int j = 0; j < 100; j++) begin
            bus.wen     = 1'b1;
            bus.ren     = 1'b1;
            bus.data_in = DATA_W'(32'h108 + j);
            check_val($sformatf("rw_dout_%0d", j), 32'(bus.data_out), 32'h100 + j);
            tick();
            check_val($sformatf("rw_count_%0d", j), 32'(bus.count), 8);
        end
        bus.wen = 1'b0;
        bus.ren = 1'b0;
        check_val("rw_head", 32'(bus.data_out), 32'h164);
        check_val("rw_ovf",  32'(bus.overflow_err), 0);
        check_val("rw_udf",  32'(bus.underflow_err), 0);

        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check_val("fl1_empty", 32'(bus.empty), 1);

        // Pop on empty, then write+pop on empty (no fall-through).
        bus.ren = 1'b1;
        tick();
        bus.ren = 1'b0;
        check_val("udf1_flag",  32'(bus.underflow_err), 1);
        check_val("udf1_count", 32'(bus.count), 0);
        check_val("udf1_pre",   32'(bus.data_out_pre), 32'h163);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check_val("clr2_udf", 32'(bus.underflow_err), 0);
        bus.wen     = 1'b1;
        bus.ren     = 1'b1;
        bus.data_in = 21'h5;
        tick();
        bus.wen = 1'b0;
        bus.ren = 1'b0;
        check_val("udf2_flag",  32'(bus.underflow_err), 1);
        check_val("udf2_count", 32'(bus.count), 1);
        check_val("udf2_dout",  32'(bus.data_out), 5);

        // Pop the 5, fill 10, then flush with write and pop asserted.
        bus.ren = 1'b1;
        tick();
        bus.ren = 1'b0;
        check_val("pop5_pre", 32'(bus.data_out_pre), 5);
        for (int k = 0; k < 10; k++) begin
            bus.wen     = 1'b1;
            bus.data_in = DATA_W'(32'h200 + k);
            tick();
        end
        bus.wen = 1'b0;
        check_val("f10_count", 32'(bus.count), 10);
        bus.flush   = 1'b1;
        bus.wen     = 1'b1;
        bus.ren     = 1'b1;
        bus.data_in = 21'h3FF;
        tick();
        bus.flush = 1'b0;
        bus.wen   = 1'b0;
        bus.ren   = 1'b0;
        check_val("fl2_count", 32'(bus.count), 0);
        check_val("fl2_empty", 32'(bus.empty), 1);
        check_val("fl2_pre",   32'(bus.data_out_pre), 5);
        check_val("fl2_dout",  32'(bus.data_out), 0);
        check_val("fl2_udf",   32'(bus.underflow_err), 1);

        // Set both flags: overflow by over-filling, underflow by empty pop.
        for (int k = 0; k < 33; k++) begin
            bus.wen     = 1'b1;
            bus.data_in = DATA_W'(32'h300 + k);
            tick();
        end
        bus.wen = 1'b0;
        check_val("set_ovf", 32'(bus.overflow_err), 1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check_val("fl3_ovf", 32'(bus.overflow_err), 1);
        check_val("fl3_udf", 32'(bus.underflow_err), 1);
        bus.err_clr = 1'b1;
        tick();
        check_val("clr3_ovf", 32'(bus.overflow_err), 0);
        check_val("clr3_udf", 32'(bus.underflow_err), 0);
        bus.ren = 1'b1;
        tick();
        bus.ren     = 1'b0;
        bus.err_clr = 1'b0;
        check_val("clrset_udf", 32'(bus.underflow_err), 1);
        check_val("clrset_ovf", 32'(bus.overflow_err), 0);

        // Reset mid-fill after a pop has loaded data_out_pre.
        for (int k = 0; k < 5; k++) begin
            bus.wen     = 1'b1;
            bus.data_in = DATA_W'(32'h400 + k);
            tick();
        end
        bus.wen = 1'b0;
        bus.ren = 1'b1;
        tick();
        bus.ren = 1'b0;
        check_val("mid_pre",   32'(bus.data_out_pre), 32'h400);
        check_val("mid_count", 32'(bus.count), 4);
        rst_n       = 1'b0;
        bus.wen     = 1'b1;
        bus.data_in = 21'h7;
        tick();
        rst_n   = 1'b1;
        bus.wen = 1'b0;
        check_reset_state();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
